// File: rtl/fas_pkg.sv
// Shared definitions for the frequency-analysis chain: FSM state codes and
// the index-width / scan-length helpers used by the FFT and peak stages.
package fas_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to index n bins (at least one bit).
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Number of bins scanned per frame.
    function automatic int scan_len(input int n, input int half, input int skip_dc);
        return ((half != 0) ? n / 2 : n) - ((skip_dc != 0) ? 1 : 0);
    endfunction

    // First bin scanned per frame.
    function automatic int first_bin(input int skip_dc);
        return (skip_dc != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/spectrum_mag_sq.sv
// Combinational magnitude-squared of one complex bin: re*re + im*im.
// Each square is non-negative and at most 2^(2W-2), so the 2W-bit unsigned
// sum cannot overflow even for the (-2^(W-1), -2^(W-1)) corner.
module spectrum_mag_sq #(
    parameter int W = 16
) (
    input  logic signed [W-1:0]   i_re,
    input  logic signed [W-1:0]   i_im,
    output logic        [2*W-1:0] o_mag
);

    logic signed [2*W-1:0] w_re_sq;
    logic signed [2*W-1:0] w_im_sq;

    assign w_re_sq = i_re * i_re;
    assign w_im_sq = i_im * i_im;
    assign o_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);

endmodule

// File: rtl/spectrum_peak_finder.sv
// Spectral peak finder: takes a whole FFT frame in one beat, scans one bin
// per cycle for the largest |X|^2 and reports the winning index with a
// one-cycle done pulse. A one-deep pending buffer absorbs a frame arriving
// mid-scan; a further frame during SCAN is dropped and flagged on overrun.
module spectrum_peak_finder
    import fas_pkg::*;
#(
    parameter int N       = 16,
    parameter int W       = 16,
    parameter int SKIP_DC = 0,
    parameter int HALF    = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_fft_valid,
    input  logic [N*2*W-1:0]            i_fft_d,
    output logic                        o_done,
    output logic [idx_w(N)-1:0]         o_freq,
    output logic [2*W-1:0]              o_peak_mag,
    output logic                        o_busy,
    output logic                        o_overrun,
    output logic [1:0]                  o_dbg_state
);

    localparam int IW   = idx_w(N);
    localparam int K    = scan_len(N, HALF, SKIP_DC);
    localparam int B0   = first_bin(SKIP_DC);
    localparam int LAST = B0 + K - 1;
    localparam int FW   = N * 2 * W;

    localparam logic [IW-1:0] B0_I   = IW'(B0);
    localparam logic [IW-1:0] LAST_I = IW'(LAST);

    logic [1:0]     r_state;
    logic [FW-1:0]  r_active;
    logic [FW-1:0]  r_pending;
    logic           r_pend_v;
    logic [IW-1:0]  r_idx;
    logic [2*W-1:0] r_max;
    logic [IW-1:0]  r_arg;
    logic           r_done;
    logic [IW-1:0]  r_freq;
    logic [2*W-1:0] r_peak;

    logic [2*W-1:0] w_bin;
    logic [2*W-1:0] w_mag;
    logic           w_take;
    logic [2*W-1:0] w_max_nxt;
    logic [IW-1:0]  w_arg_nxt;

    // N:1 bin select from the active frame on the scan index
    always_comb begin
        w_bin = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) begin
                w_bin = r_active[k*2*W +: 2*W];
            end
        end
    end

    spectrum_mag_sq #(.W(W)) u_mag (
        .i_re  (w_bin[2*W-1:W]),
        .i_im  (w_bin[W-1:0]),
        .o_mag (w_mag)
    );

    // Strictly-greater compare keeps the lowest index on ties; the first
    // scanned bin always loads so the running max needs no sentinel.
    assign w_take    = (r_idx == B0_I) || (w_mag > r_max);
    assign w_max_nxt = w_take ? w_mag : r_max;
    assign w_arg_nxt = w_take ? r_idx : r_arg;

    // Scan FSM, frame buffering and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_pend_v <= 1'b0;
            r_idx    <= '0;
            r_max    <= '0;
            r_arg    <= '0;
            r_done   <= 1'b0;
            r_freq   <= '0;
            r_peak   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_fft_valid) begin
                        r_active <= i_fft_d;
                        r_idx    <= B0_I;
                        r_max    <= '0;
                        r_arg    <= B0_I;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_max <= w_max_nxt;
                    r_arg <= w_arg_nxt;
                    r_idx <= r_idx + 1'b1;
                    if (i_fft_valid && !r_pend_v) begin
                        r_pending <= i_fft_d;
                        r_pend_v  <= 1'b1;
                    end
                    if (r_idx == LAST_I) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_freq  <= w_arg_nxt;
                        r_peak  <= w_max_nxt;
                    end
                end
                ST_DONE: begin
                    r_idx <= B0_I;
                    r_max <= '0;
                    r_arg <= B0_I;
                    if (r_pend_v) begin
                        // Pending frame starts next; a same-cycle arrival
                        // refills the pending slot, so nothing is lost.
                        r_active <= r_pending;
                        r_state  <= ST_SCAN;
                        if (i_fft_valid) begin
                            r_pending <= i_fft_d;
                        end else begin
                            r_pend_v <= 1'b0;
                        end
                    end else if (i_fft_valid) begin
                        r_active <= i_fft_d;
                        r_state  <= ST_SCAN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Overrun flags the dropped beat itself, so it is combinational.
    assign o_overrun   = i_fft_valid && !i_rst && (r_state == ST_SCAN) && r_pend_v;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_freq      = r_freq;
    assign o_peak_mag  = r_peak;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed bench for spectrum_peak_finder: one default instance and one
// SKIP_DC=1/HALF=1 instance, checked with immediate assertions.
module tb_spectrum_peak_finder;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int FW = N * 2 * W;

    // clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default instance
    logic          fft_valid;
    logic [FW-1:0] fft_d;
    logic          done;
    logic [3:0]    freq;
    logic [31:0]   peak_mag;
    logic          busy;
    logic          overrun;
    logic [1:0]    dbg_state;

    // SKIP_DC=1, HALF=1 instance
    logic          m_valid;
    logic [FW-1:0] m_d;
    logic          m_done;
    logic [3:0]    m_freq;
    logic [31:0]   m_peak;
    logic          m_busy;
    logic          m_overrun;
    logic [1:0]    m_dbg_state;

    spectrum_peak_finder #(.N(N), .W(W), .SKIP_DC(0), .HALF(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_fft_valid(fft_valid), .i_fft_d(fft_d),
        .o_done(done), .o_freq(freq), .o_peak_mag(peak_mag), .o_busy(busy),
        .o_overrun(overrun), .o_dbg_state(dbg_state)
    );

    spectrum_peak_finder #(.N(N), .W(W), .SKIP_DC(1), .HALF(1)) dut_m (
        .i_clk(clk), .i_rst(rst), .i_fft_valid(m_valid), .i_fft_d(m_d),
        .o_done(m_done), .o_freq(m_freq), .o_peak_mag(m_peak), .o_busy(m_busy),
        .o_overrun(m_overrun), .o_dbg_state(m_dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // observations from run_sched
    int         got_cyc[$];
    logic [3:0] got_freq[$];
    int         ovr_cnt;
    int         ovr_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] put_bin(input logic [FW-1:0] f, input int k,
                                              input logic [W-1:0] re, input logic [W-1:0] im);
        f[k*2*W +: 2*W] = {re, im};
        return f;
    endfunction

    function automatic logic [FW-1:0] one_bin(input int k, input logic [W-1:0] re,
                                              input logic [W-1:0] im);
        logic [FW-1:0] z;
        z = '0;
        return put_bin(z, k, re, im);
    endfunction

    // Drive one frame into the selected instance and wait (bounded) for done.
    task automatic single(input bit sel, input logic [FW-1:0] f, input int exp_lat,
                          input logic [3:0] exp_f, input logic [31:0] exp_m, input string tag);
        int lat;
        if (sel) begin m_d = f; m_valid = 1'b1; end
        else begin fft_d = f; fft_valid = 1'b1; end
        step();
        m_valid   = 1'b0;
        fft_valid = 1'b0;
        lat = 1;
        while (!(sel ? m_done : done) && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_freq"}, 64'(sel ? m_freq : freq), 64'(exp_f));
        chk({tag, "_mag"},  64'(sel ? m_peak : peak_mag), 64'(exp_m));
        step();
        chk({tag, "_pulse"}, 64'(sel ? m_done : done), 64'd0);
    endtask

    // Run ncyc cycles on the default instance: frames at c0/c1/c2, reset at rst_t.
    task automatic run_sched(input int ncyc, input int c0, input int c1, input int c2,
                             input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                             input logic [FW-1:0] f2, input int rst_t);
        got_cyc.delete();
        got_freq.delete();
        ovr_cnt = 0;
        ovr_cyc = -1;
        for (int t = 0; t < ncyc; t++) begin
            if (done) begin
                got_cyc.push_back(t);
                got_freq.push_back(freq);
            end
            fft_valid = (t == c0) || (t == c1) || (t == c2);
            fft_d     = (t == c0) ? f0 : (t == c1) ? f1 : (t == c2) ? f2 : '0;
            rst       = (t == rst_t);
            #1;
            if (overrun) begin
                ovr_cnt++;
                ovr_cyc = t;
            end
            @(posedge clk);
            #1;
        end
        fft_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [FW-1:0] f;
        logic [FW-1:0] fa;
        logic [FW-1:0] fb;
        logic [FW-1:0] fc;

        rst = 1'b1; fft_valid = 1'b0; fft_d = '0; m_valid = 1'b0; m_d = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // reset state
        chk("rst_done",    64'(done), 64'd0);
        chk("rst_freq",    64'(freq), 64'd0);
        chk("rst_mag",     64'(peak_mag), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_state",   64'(dbg_state), 64'd0);
        chk("rst_m_busy",  64'(m_busy), 64'd0);
        chk("rst_m_freq",  64'(m_freq), 64'd0);

        // single frame: bin5 = {300,-400} -> 90000+160000
        single(1'b0, one_bin(5, 16'd300, 16'hFE70), 17, 4'd5, 32'd250000, "single");

        // tie between bins 3 and 9
        f = put_bin(one_bin(3, 16'd100, 16'd0), 9, 16'd100, 16'd0);
        single(1'b0, f, 17, 4'd3, 32'd10000, "tie");

        // last bin wins: bin0 {100,100}=20000, bin15 {-200,0}=40000
        f = put_bin(one_bin(0, 16'd100, 16'd100), 15, 16'hFF38, 16'd0);
        single(1'b0, f, 17, 4'd15, 32'd40000, "lastbin");

        // all-zero frame reports bin 0
        single(1'b0, '0, 17, 4'd0, 32'd0, "zero");

        // SKIP_DC + HALF: bin0 ignored, bin12 outside the half spectrum
        f = put_bin(one_bin(0, 16'd1000, 16'd0), 6, 16'd10, 16'd10);
        f = put_bin(f, 12, 16'd500, 16'd0);
        single(1'b1, f, 8, 4'd6, 32'd200, "mode");
        single(1'b1, '0, 8, 4'd1, 32'd0, "mode_zero");
        single(1'b1, one_bin(2, 16'h8000, 16'h8000), 8, 4'd2, 32'h8000_0000, "mode_worst");

        // back-to-back: frames on 0, 2, 4; third is dropped
        fa = one_bin(1, 16'd50, 16'd0);
        fb = one_bin(7, 16'd0, 16'd60);
        fc = one_bin(14, 16'd70, 16'd70);
        run_sched(40, 0, 2, 4, fa, fb, fc, -1);
        chk("b2b_ndone",   64'(got_cyc.size()), 64'd2);
        chk("b2b_cyc0",    64'((got_cyc.size() > 0) ? got_cyc[0] : -1), 64'd17);
        chk("b2b_freq0",   64'((got_freq.size() > 0) ? got_freq[0] : 4'hF), 64'd1);
        chk("b2b_cyc1",    64'((got_cyc.size() > 1) ? got_cyc[1] : -1), 64'd34);
        chk("b2b_freq1",   64'((got_freq.size() > 1) ? got_freq[1] : 4'hF), 64'd7);
        chk("b2b_ovr_cnt", 64'(ovr_cnt), 64'd1);
        chk("b2b_ovr_cyc", 64'(ovr_cyc), 64'd4);
        chk("b2b_idle",    64'(busy), 64'd0);

        // overlap in DONE: A@0, B@3, C@17 -> three results, no overrun
        fa = one_bin(2, 16'd5, 16'd5);
        fb = one_bin(11, 16'hFFF0, 16'd0);
        fc = one_bin(15, 16'd1, 16'd0);
        run_sched(60, 0, 3, 17, fa, fb, fc, -1);
        chk("ovl_ndone", 64'(got_cyc.size()), 64'd3);
        chk("ovl_cyc0",  64'((got_cyc.size() > 0) ? got_cyc[0] : -1), 64'd17);
        chk("ovl_cyc1",  64'((got_cyc.size() > 1) ? got_cyc[1] : -1), 64'd34);
        chk("ovl_cyc2",  64'((got_cyc.size() > 2) ? got_cyc[2] : -1), 64'd51);
        chk("ovl_freq0", 64'((got_freq.size() > 0) ? got_freq[0] : 4'h0), 64'd2);
        chk("ovl_freq1", 64'((got_freq.size() > 1) ? got_freq[1] : 4'h0), 64'd11);
        chk("ovl_freq2", 64'((got_freq.size() > 2) ? got_freq[2] : 4'h0), 64'd15);
        chk("ovl_ovr",   64'(ovr_cnt), 64'd0);

        // reset mid-scan with a pending frame
        fa = one_bin(4, 16'd9, 16'd0);
        fb = one_bin(8, 16'd9, 16'd9);
        run_sched(9, 0, 2, -1, fa, fb, '0, 8);
        rst = 1'b0;
        #1;
        chk("mrst_ndone",   64'(got_cyc.size()), 64'd0);
        chk("mrst_done",    64'(done), 64'd0);
        chk("mrst_freq",    64'(freq), 64'd0);
        chk("mrst_mag",     64'(peak_mag), 64'd0);
        chk("mrst_busy",    64'(busy), 64'd0);
        chk("mrst_overrun", 64'(overrun), 64'd0);
        run_sched(30, -1, -1, -1, '0, '0, '0, -1);
        chk("mrst_no_pend", 64'(got_cyc.size()), 64'd0);
        single(1'b0, one_bin(10, 16'd3, 16'hFFFC), 17, 4'd10, 32'd25, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
